// File: rtl/aw_pkg.sv
// Shared definitions for the AXI write-address stage: command entry field
// offsets, write-order descriptor layout, FSM encoding and burst sizing.
package aw_pkg;

  localparam int unsigned NUM_SRC   = 8;
  localparam int unsigned SRC_W     = 3;
  localparam int unsigned CMD_W     = 97;
  localparam int unsigned OUT_W     = 4;

  // Command entry fields; bits [96:85] are reserved.
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned ADDR_MSB  = 63;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned LEN_LSB   = 64;
  localparam int unsigned SIZE_W    = 3;
  localparam int unsigned SIZE_LSB  = 72;
  localparam int unsigned BURST_W   = 2;
  localparam int unsigned BURST_LSB = 75;
  localparam int unsigned ID_W      = 8;
  localparam int unsigned ID_LSB    = 77;

  // Write-order descriptor: {src, id, bytecount, addr_lo}.
  localparam int unsigned WQ_W        = 33;
  localparam int unsigned BCNT_W      = 16;
  localparam int unsigned ALO_W       = 6;
  localparam int unsigned WQ_ALO_LSB  = 0;
  localparam int unsigned WQ_BCNT_LSB = 6;
  localparam int unsigned WQ_ID_LSB   = 22;
  localparam int unsigned WQ_SRC_LSB  = 30;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [ID_W-1:0]   id;
    logic [BCNT_W-1:0] bcnt;
    logic [ALO_W-1:0]  alo;
  } wq_desc_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Burst length in bytes; 256 beats of 128 bytes still fits in 16 bits.
  function automatic logic [BCNT_W-1:0] burst_bytes(input logic [LEN_W-1:0]  len,
                                                    input logic [SIZE_W-1:0] size);
    return BCNT_W'((BCNT_W'(len) + BCNT_W'(1)) << size);
  endfunction

endpackage

// File: rtl/aw_channel_if.sv
// AXI write-address channel bundle.
//   master: drives awvalid and the AW payload, samples awready.
//   slave : samples awvalid and the AW payload, drives awready.
interface aw_channel_if;
  import aw_pkg::*;

  logic                 awvalid;
  logic                 awready;
  logic [ADDR_W-1:0]    awaddr;
  logic [LEN_W-1:0]     awlen;
  logic [SIZE_W-1:0]    awsize;
  logic [BURST_W-1:0]   awburst;
  logic [ID_W-1:0]      awid;

  modport master (output awvalid, awaddr, awlen, awsize, awburst, awid,
                  input  awready);
  modport slave  (input  awvalid, awaddr, awlen, awsize, awburst, awid,
                  output awready);
endinterface

// File: rtl/rr_arb8.sv
// Combinational 8-way round-robin arbiter.
//   req         : request per source
//   last_grant  : previous winner; the scan starts one past it
//   grant       : winning index (0 when nothing requests)
//   grant_valid : at least one request present
module rr_arb8 (
  input  logic [7:0] req,
  input  logic [2:0] last_grant,
  output logic [2:0] grant,
  output logic       grant_valid
);

  logic [2:0] idx;

  // Offsets 1..8 wrap mod 8, so last_grant itself is checked last.
  always_comb begin
    grant       = 3'd0;
    grant_valid = 1'b0;
    idx         = 3'd0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = last_grant + 3'(k);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aw_channel.sv
// AXI write-address stage: round-robin picks one of eight command FIFOs,
// presents the burst on AW, pops the FIFO and pushes a write-order
// descriptor on the handshake, and throttles on outstanding B responses.
//   clk, reset          : clock, synchronous active-high reset
//   cmd_empty/data/rd   : per-source command FIFO read side
//   aw                  : AXI AW channel (master side)
//   wq_full/push/data   : write-order queue towards the write-data channel
//   bvalid, bready      : B handshake observed for outstanding tracking
//   outstanding         : bursts issued without a B response
//   err_4k              : pulse, issued burst crosses a 4 KB boundary
//   err_b_underflow     : sticky, B handshake seen with nothing outstanding
module aw_channel
  import aw_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       cmd_empty,
  input  logic [NUM_SRC*CMD_W-1:0] cmd_data,
  output logic [NUM_SRC-1:0]       cmd_rd,
  aw_channel_if.master             aw,
  input  logic                     wq_full,
  output logic                     wq_push,
  output logic [WQ_W-1:0]          wq_data,
  input  logic                     bvalid,
  input  logic                     bready,
  output logic [OUT_W-1:0]         outstanding,
  output logic                     err_4k,
  output logic                     err_b_underflow
);

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [SIZE_W-1:0]    size_q, size_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [OUT_W-1:0]     outst_q, outst_d;
  logic                 b_uf_q, b_uf_d;

  logic [SRC_W-1:0]     arb_grant;
  logic                 arb_valid;
  logic [CMD_W-1:0]     entry;
  logic [BCNT_W-1:0]    bcnt;
  logic                 aw_hs;
  logic                 b_hs;
  logic                 can_issue;
  wq_desc_t             desc;
  logic                 unused_rsvd;

  rr_arb8 u_arb (
    .req         (~cmd_empty),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign entry       = cmd_data[32'(arb_grant)*CMD_W +: CMD_W];
  assign unused_rsvd = ^entry[CMD_W-1:ID_LSB+ID_W];
  assign bcnt        = burst_bytes(len_q, size_q);
  // A handshake coinciding with reset is dropped: no pop, no descriptor.
  assign aw_hs       = (state_q == ISSUE) & aw.awready & ~reset;
  assign b_hs        = bvalid & bready;
  assign can_issue   = arb_valid & ~wq_full & (32'(outst_q) < MAX_OUTSTANDING);

  // Next-state, handshake side effects and outstanding accounting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    id_d         = id_q;
    outst_d      = outst_q;
    b_uf_d       = b_uf_q;
    cmd_rd       = '0;
    wq_push      = 1'b0;
    err_4k       = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_issue) begin
          grant_d = arb_grant;
          addr_d  = entry[ADDR_MSB:ADDR_LSB];
          len_d   = entry[LEN_LSB +: LEN_W];
          size_d  = entry[SIZE_LSB +: SIZE_W];
          burst_d = entry[BURST_LSB +: BURST_W];
          id_d    = entry[ID_LSB +: ID_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (aw_hs) begin
          cmd_rd[grant_q] = 1'b1;
          wq_push         = 1'b1;
          err_4k          = (17'(addr_q[11:0]) + 17'(bcnt) - 17'd1) > 17'h00FFF;
          last_grant_d    = grant_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (b_hs && (outst_q == '0)) begin
      b_uf_d = 1'b1;
    end
    if (aw_hs && !b_hs) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (b_hs && !aw_hs && (outst_q != '0)) begin
      outst_d = outst_q - OUT_W'(1);
    end
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      outst_q      <= '0;
      b_uf_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      id_q         <= id_d;
      outst_q      <= outst_d;
      b_uf_q       <= b_uf_d;
    end
  end

  assign aw.awvalid      = (state_q == ISSUE);
  assign aw.awaddr       = addr_q;
  assign aw.awlen        = len_q;
  assign aw.awsize       = size_q;
  assign aw.awburst      = burst_q;
  assign aw.awid         = id_q;

  assign desc.src        = grant_q;
  assign desc.id         = id_q;
  assign desc.bcnt       = bcnt;
  assign desc.alo        = addr_q[ALO_W-1:0];
  assign wq_data         = desc;

  assign outstanding     = outst_q;
  assign err_b_underflow = b_uf_q;

endmodule

// File: tb/tb_aw_channel.sv
// Self-checking bench for aw_channel: bench-side command FIFOs, directed
// scenarios and a randomized phase, all compared every cycle against a
// transaction-level reference model.
module tb_aw_channel;
  import aw_pkg::*;

  localparam int MAXO  = 2;
  localparam int DEPTH = 32;

  typedef logic [CMD_W-1:0] ent_t;

  logic                     clk;
  logic                     reset;
  logic [NUM_SRC-1:0]       cmd_empty;
  logic [NUM_SRC*CMD_W-1:0] cmd_data;
  logic [NUM_SRC-1:0]       cmd_rd;
  logic                     wq_full;
  logic                     wq_push;
  logic [WQ_W-1:0]          wq_data;
  logic                     bvalid;
  logic                     bready;
  logic [OUT_W-1:0]         outstanding;
  logic                     err_4k;
  logic                     err_b_underflow;

  aw_channel_if aw_if ();

  aw_channel #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_empty       (cmd_empty),
    .cmd_data        (cmd_data),
    .cmd_rd          (cmd_rd),
    .aw              (aw_if),
    .wq_full         (wq_full),
    .wq_push         (wq_push),
    .wq_data         (wq_data),
    .bvalid          (bvalid),
    .bready          (bready),
    .outstanding     (outstanding),
    .err_4k          (err_4k),
    .err_b_underflow (err_b_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bench-side command FIFOs.
  ent_t mem [NUM_SRC][DEPTH];
  int   head [NUM_SRC];
  int   cnt  [NUM_SRC];

  task automatic drive_fifo();
    for (int s = 0; s < NUM_SRC; s++) begin
      cmd_empty[s] = (cnt[s] == 0);
      cmd_data[s*CMD_W +: CMD_W] = (cnt[s] > 0) ? mem[s][head[s]] : ent_t'(0);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [7:0] id);
    ent_t e;
    e = '0;
    e[63:0]  = addr;
    e[71:64] = len;
    e[74:72] = size;
    e[76:75] = burst;
    e[84:77] = id;
    e[96:85] = 12'($urandom);
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    logic [63:0] a;
    a = {$urandom, $urandom};
    if ($urandom_range(1, 0) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(255, 0));
    return mk(a, 8'($urandom), 3'($urandom), 2'($urandom), 8'($urandom));
  endfunction

  task automatic push_ent(input int s, input ent_t e);
    if (cnt[s] < DEPTH) begin
      mem[s][(head[s] + cnt[s]) % DEPTH] = e;
      cnt[s]++;
    end
    drive_fifo();
  endtask

  // Reference model: one burst in flight or none, plain-integer bookkeeping.
  bit          m_busy, n_busy;
  int          m_src, n_src, m_last, n_last, m_out, n_out, pop_src;
  bit          m_err, n_err;
  logic [63:0] m_addr, n_addr;
  logic [7:0]  m_len, n_len, m_id, n_id;
  logic [2:0]  m_size, n_size;
  logic [1:0]  m_burst, n_burst;

  // Observations of the DUT.
  int          cyc = 0;
  int          seen_src[$];
  int          seen_cyc[$];
  int          n_rd_seen = 0;
  int          n_push_seen = 0;
  logic [32:0] last_wq;
  logic        last_err4k;

  task automatic tick();
    int         bytes, win, s, rd_idx;
    bit         hs, b, found;
    logic [7:0] exp_rd;
    logic [32:0] exp_wq;
    bit         exp_e4k;
    ent_t       e;

    @(negedge clk);
    bytes   = (int'(m_len) + 1) * (1 << m_size);
    hs      = m_busy && (aw_if.awready === 1'b1) && !reset;
    exp_rd  = hs ? 8'(1 << m_src) : 8'h00;
    exp_wq  = {3'(m_src), m_id, 16'(bytes), m_addr[5:0]};
    exp_e4k = hs && ((int'(m_addr[11:0]) + bytes - 1) > 4095);

    check_eq("awvalid", 64'(aw_if.awvalid), 64'(m_busy));
    check_eq("awaddr", aw_if.awaddr, m_addr);
    check_eq("awlen", 64'(aw_if.awlen), 64'(m_len));
    check_eq("awsize", 64'(aw_if.awsize), 64'(m_size));
    check_eq("awburst", 64'(aw_if.awburst), 64'(m_burst));
    check_eq("awid", 64'(aw_if.awid), 64'(m_id));
    check_eq("cmd_rd", 64'(cmd_rd), 64'(exp_rd));
    check_eq("wq_push", 64'(wq_push), 64'(hs));
    if (hs) check_eq("wq_data", 64'(wq_data), 64'(exp_wq));
    check_eq("err_4k", 64'(err_4k), 64'(exp_e4k));
    check_eq("outstanding", 64'(outstanding), 64'(m_out));
    check_eq("err_b_underflow", 64'(err_b_underflow), 64'(m_err));

    if (cmd_rd != '0) begin
      rd_idx = 0;
      for (int i = 0; i < NUM_SRC; i++) if (cmd_rd[i]) rd_idx = i;
      n_rd_seen++;
      seen_src.push_back(rd_idx);
    end
    if (wq_push) begin
      n_push_seen++;
      last_wq    = wq_data;
      last_err4k = err_4k;
      seen_cyc.push_back(cyc);
    end

    n_busy = m_busy; n_src = m_src; n_last = m_last; n_out = m_out; n_err = m_err;
    n_addr = m_addr; n_len = m_len; n_size = m_size; n_burst = m_burst; n_id = m_id;
    pop_src = -1;
    if (reset) begin
      n_busy = 0; n_src = 0; n_last = NUM_SRC - 1; n_out = 0; n_err = 0;
      n_addr = '0; n_len = '0; n_size = '0; n_burst = '0; n_id = '0;
    end else begin
      b = bvalid && bready;
      if (b && m_out == 0) n_err = 1;
      if (b && m_out == 0 && !hs) n_out = 0;
      else n_out = m_out + int'(hs) - int'(b);
      if (hs) begin
        n_busy  = 0;
        n_last  = m_src;
        pop_src = m_src;
      end else if (!m_busy && !wq_full && m_out < MAXO) begin
        found = 0;
        win   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
          s = (m_last + k) % NUM_SRC;
          if (!found && cnt[s] > 0) begin
            found = 1;
            win   = s;
          end
        end
        if (found) begin
          e       = mem[win][head[win]];
          n_busy  = 1;
          n_src   = win;
          n_addr  = e[63:0];
          n_len   = e[71:64];
          n_size  = e[74:72];
          n_burst = e[76:75];
          n_id    = e[84:77];
        end
      end
    end

    @(posedge clk);
    m_busy = n_busy; m_src = n_src; m_last = n_last; m_out = n_out; m_err = n_err;
    m_addr = n_addr; m_len = n_len; m_size = n_size; m_burst = n_burst; m_id = n_id;
    if (pop_src >= 0 && cnt[pop_src] > 0) begin
      head[pop_src] = (head[pop_src] + 1) % DEPTH;
      cnt[pop_src]--;
    end
    cyc++;
    #1;
    drive_fifo();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_push(input int lim, input string tag);
    int n0, k;
    n0 = n_push_seen;
    k  = 0;
    while (n_push_seen == n0 && k < lim) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(n_push_seen - n0), 64'd1);
  endtask

  task automatic wait_awvalid(input int lim, input string tag);
    int k;
    k = 0;
    while (aw_if.awvalid !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(aw_if.awvalid), 64'd1);
  endtask

  task automatic drain_b();
    int k;
    k = 0;
    while (m_out > 0 && k < 20) begin
      bvalid = 1'b1; bready = 1'b1;
      tick();
      k++;
    end
    bvalid = 1'b0; bready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_order[5];
    int          q0, p0, r0;
    logic [63:0] addr0;
    logic [7:0]  id0;

    exp_order = '{0, 2, 5, 0, 2};
    for (int s = 0; s < NUM_SRC; s++) begin
      head[s] = 0;
      cnt[s]  = 0;
    end
    m_busy = 0; m_src = 0; m_last = NUM_SRC - 1; m_out = 0; m_err = 0;
    m_addr = '0; m_len = '0; m_size = '0; m_burst = '0; m_id = '0;
    reset = 1'b1; wq_full = 1'b0; bvalid = 1'b0; bready = 1'b0;
    aw_if.awready = 1'b0;
    cmd_data = '0;
    drive_fifo();

    // Reset state.
    repeat (3) tick();
    check_eq("rst_awvalid", 64'(aw_if.awvalid), 64'd0);
    check_eq("rst_cmd_rd", 64'(cmd_rd), 64'd0);
    check_eq("rst_outstanding", 64'(outstanding), 64'd0);
    check_eq("rst_awaddr", aw_if.awaddr, 64'd0);
    reset = 1'b0;

    // Single source 3 burst, awready tied high.
    aw_if.awready = 1'b1;
    push_ent(3, mk(64'h1000, 8'd3, 3'd6, 2'd1, 8'h5A));
    tick();
    check_eq("s1_awvalid_after_grant", 64'(aw_if.awvalid), 64'd1);
    run_until_push(4, "s1_push");
    check_eq("s1_wq_data", 64'(last_wq), 64'({3'd3, 8'h5A, 16'd256, 6'd0}));
    check_eq("s1_rd_src", 64'(seen_src[seen_src.size()-1]), 64'd3);
    check_eq("s1_rd_count", 64'(n_rd_seen), 64'd1);
    check_eq("s1_outstanding", 64'(outstanding), 64'd1);
    tick();
    check_eq("s1_rd_single_pulse", 64'(n_rd_seen), 64'd1);
    drain_b();

    // Round robin over sources 0, 2, 5 from reset priority.
    do_reset();
    q0 = seen_src.size();
    p0 = seen_cyc.size();
    push_ent(0, rnd_ent()); push_ent(0, rnd_ent());
    push_ent(2, rnd_ent()); push_ent(2, rnd_ent());
    push_ent(5, rnd_ent());
    for (int k = 0; k < 30 && (seen_src.size() - q0) < 5; k++) begin
      bvalid = (m_out > 0); bready = (m_out > 0);
      tick();
    end
    bvalid = 1'b0; bready = 1'b0;
    check_eq("s2_issue_count", 64'(seen_src.size() - q0), 64'd5);
    if (seen_src.size() - q0 >= 5 && seen_cyc.size() - p0 >= 5) begin
      for (int i = 0; i < 5; i++) check_eq("s2_order", 64'(seen_src[q0+i]), 64'(exp_order[i]));
      for (int i = 1; i < 5; i++) check_eq("s2_spacing", 64'(seen_cyc[p0+i] - seen_cyc[p0+i-1]), 64'd2);
    end
    drain_b();

    // awready held low for 5 cycles.
    aw_if.awready = 1'b0;
    push_ent(1, rnd_ent());
    wait_awvalid(5, "s3_awvalid_up");
    addr0 = aw_if.awaddr;
    id0   = aw_if.awid;
    r0    = n_rd_seen;
    p0    = n_push_seen;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("s3_addr_stable", aw_if.awaddr, addr0);
      check_eq("s3_id_stable", 64'(aw_if.awid), 64'(id0));
    end
    check_eq("s3_no_early_rd", 64'(n_rd_seen - r0), 64'd0);
    aw_if.awready = 1'b1;
    tick();
    check_eq("s3_rd_once", 64'(n_rd_seen - r0), 64'd1);
    check_eq("s3_push_once", 64'(n_push_seen - p0), 64'd1);
    drain_b();

    // Outstanding limit with no B responses.
    do_reset();
    p0 = n_push_seen;
    push_ent(4, rnd_ent()); push_ent(4, rnd_ent()); push_ent(4, rnd_ent());
    repeat (10) tick();
    check_eq("s4_issues_at_limit", 64'(n_push_seen - p0), 64'd2);
    check_eq("s4_throttled_awvalid", 64'(aw_if.awvalid), 64'd0);
    check_eq("s4_outstanding", 64'(outstanding), 64'd2);
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    run_until_push(6, "s4_third_issue");
    check_eq("s4_outstanding_after", 64'(outstanding), 64'd2);

    // Simultaneous AW and B at outstanding 1, then lone B at 0.
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    aw_if.awready = 1'b0;
    push_ent(6, rnd_ent());
    wait_awvalid(5, "s5_awvalid_up");
    p0 = n_push_seen;
    aw_if.awready = 1'b1; bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    check_eq("s5_simul_push", 64'(n_push_seen - p0), 64'd1);
    check_eq("s5_simul_outstanding", 64'(outstanding), 64'd1);
    drain_b();
    check_eq("s5_drained", 64'(outstanding), 64'd0);
    check_eq("s5_no_underflow_yet", 64'(err_b_underflow), 64'd0);
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    check_eq("s5_underflow_set", 64'(err_b_underflow), 64'd1);
    check_eq("s5_outstanding_zero", 64'(outstanding), 64'd0);
    tick();
    check_eq("s5_underflow_sticky", 64'(err_b_underflow), 64'd1);

    // 4 KB crossing and the exact-fit boundary.
    push_ent(7, mk(64'h0FC0, 8'd1, 3'd6, 2'd1, 8'h11));
    run_until_push(4, "s6_cross_push");
    check_eq("s6_err_4k_cross", 64'(last_err4k), 64'd1);
    push_ent(7, mk(64'h0F80, 8'd1, 3'd6, 2'd1, 8'h12));
    run_until_push(4, "s6_fit_push");
    check_eq("s6_err_4k_fit", 64'(last_err4k), 64'd0);
    drain_b();

    // Reset while a burst waits for awready.
    aw_if.awready = 1'b0;
    push_ent(2, rnd_ent());
    wait_awvalid(5, "s7_awvalid_up");
    r0 = n_rd_seen;
    reset = 1'b1; aw_if.awready = 1'b1;
    tick();
    reset = 1'b0; aw_if.awready = 1'b0;
    check_eq("s7_awvalid_dropped", 64'(aw_if.awvalid), 64'd0);
    check_eq("s7_outstanding_reset", 64'(outstanding), 64'd0);
    check_eq("s7_no_rd", 64'(n_rd_seen - r0), 64'd0);
    check_eq("s7_underflow_cleared", 64'(err_b_underflow), 64'd0);
    aw_if.awready = 1'b1;
    run_until_push(6, "s7_reissue");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3, 0) == 0) push_ent(int'($urandom_range(NUM_SRC - 1, 0)), rnd_ent());
      aw_if.awready = ($urandom_range(2, 0) != 0);
      wq_full       = m_busy ? 1'b0 : ($urandom_range(4, 0) == 0);
      bvalid        = (m_out > 0) && ($urandom_range(1, 0) == 1);
      bready        = ($urandom_range(1, 0) == 1);
      reset         = ($urandom_range(149, 0) == 0);
      tick();
    end
    reset = 1'b0; bvalid = 1'b0; bready = 1'b0; wq_full = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
